alu_pi_master: RTL and testbench

Processor-interface initiator that drives the ALU register block's 8-bit register bus on behalf of a 32-bit command stream. It accepts one command (function code plus two 32-bit operands) and writes the operand bytes and a control byte with go set. It then polls the status busy bit until clear, reads back the quotient and remainder bytes, and presents a 32-bit response. It sits between the fractal iteration engine and the ALU register block, so the engine can use the ALU without byte-level bus handling.

---
 rtl/alu_pi_master.sv | 210 +++++++++++++++++++++
 tb/tb_alu_pi_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pi_master.sv
// alu_pi_master: turns one 32-bit ALU command into byte-wide register bus
// traffic (operand writes, go, status poll, result reads) and returns a
// 32-bit quotient/remainder response. A poll timeout pulses the ALU clear bit
// and reports an error response instead.
module alu_pi_master #(
  parameter logic [3:0] ADDR_CTRL    = 4'h0,
  parameter logic [3:0] ADDR_A0      = 4'h1,
  parameter logic [3:0] ADDR_B0      = 4'h5,
  parameter logic [3:0] ADDR_Q0      = 4'h1,
  parameter logic [3:0] ADDR_R0      = 4'h5,
  parameter logic       INT_MASK     = 1'b0,
  parameter int         POLL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_func,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_q,
  output logic [31:0] rsp_r,
  output logic        rsp_err,
  output logic        pi_blk_sel,
  output logic [3:0]  pi_addr,
  output logic        pi_wr_en,
  output logic        pi_rd_en,
  output logic [7:0]  pi_wr_data,
  input  logic [7:0]  pi_rd_data
);

  localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);

  // The state names the bus operation currently presented on pi_*.
  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_POLL,
    S_RD_Q, S_RD_R, S_CLR_SET, S_CLR_REL, S_RSP
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] poll_cnt;
  logic [3:0]       func_q;
  logic [31:0]      op_a_q, op_b_q;
  logic [31:0]      a_src;
  logic             accept;
  logic             busy;
  logic             wr_d, rd_d;
  logic [3:0]       addr_d;
  logic [7:0]       wdata_d;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  // Control byte layout: {func, clr, int_mask, en, go}.
  function automatic logic [7:0] ctrl_byte(input logic [3:0] f, input logic clr,
                                           input logic go);
    return {f, clr, INT_MASK, 1'b1, go};
  endfunction

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == S_RSP);
  assign busy      = pi_rd_data[0];
  // The first A byte goes out on the acceptance edge, before op_a_q is loaded.
  assign a_src     = (state == S_IDLE) ? cmd_op_a : op_a_q;

  // State, byte index, poll counter, response and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      poll_cnt   <= '0;
      rsp_q      <= 32'd0;
      rsp_r      <= 32'd0;
      rsp_err    <= 1'b0;
      pi_blk_sel <= 1'b0;
      pi_wr_en   <= 1'b0;
      pi_rd_en   <= 1'b0;
      pi_addr    <= 4'd0;
      pi_wr_data <= 8'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pi_blk_sel <= wr_d | rd_d;
      pi_wr_en   <= wr_d;
      pi_rd_en   <= rd_d;
      pi_addr    <= addr_d;
      pi_wr_data <= wdata_d;
      if (accept) begin
        poll_cnt <= '0;
        rsp_q    <= 32'd0;
        rsp_r    <= 32'd0;
        rsp_err  <= 1'b0;
      end
      if (state == S_POLL && busy) poll_cnt <= poll_cnt + CNT_W'(1);
      if (state == S_RD_Q) rsp_q[{idx, 3'b000} +: 8] <= pi_rd_data;
      if (state == S_RD_R) rsp_r[{idx, 3'b000} +: 8] <= pi_rd_data;
      if (state == S_CLR_REL) begin
        rsp_err <= 1'b1;
        rsp_q   <= 32'd0;
        rsp_r   <= 32'd0;
      end
    end
  end

  // Command fields are held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      func_q <= cmd_func;
      op_a_q <= cmd_op_a;
      op_b_q <= cmd_op_b;
    end
  end

  // Next-state: the 2-bit index wraps to 0 exactly when a 4-byte phase ends.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_WR_A;
          idx_nxt   = 2'd0;
        end
      end
      S_WR_A: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = S_WR_B;
      end
      S_WR_B: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = S_WR_GO;
      end
      S_WR_GO: state_nxt = S_POLL;
      S_POLL: begin
        if (!busy) begin
          state_nxt = S_RD_Q;
          idx_nxt   = 2'd0;
        end else if (poll_cnt == CNT_W'(POLL_TIMEOUT - 1)) begin
          state_nxt = S_CLR_SET;
        end
      end
      S_RD_Q: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = S_RD_R;
      end
      S_RD_R: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = S_RSP;
      end
      S_CLR_SET: state_nxt = S_CLR_REL;
      S_CLR_REL: state_nxt = S_RSP;
      S_RSP:     if (rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bus operation for the upcoming cycle, registered onto pi_* above.
  always_comb begin
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = 4'd0;
    wdata_d = 8'd0;
    case (state_nxt)
      S_WR_A: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_A0 + {2'b00, idx_nxt};
        wdata_d = byte_of(a_src, idx_nxt);
      end
      S_WR_B: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_B0 + {2'b00, idx_nxt};
        wdata_d = byte_of(op_b_q, idx_nxt);
      end
      S_WR_GO: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_byte(func_q, 1'b0, 1'b1);
      end
      S_POLL: begin
        rd_d   = 1'b1;
        addr_d = ADDR_CTRL;
      end
      S_RD_Q: begin
        rd_d   = 1'b1;
        addr_d = ADDR_Q0 + {2'b00, idx_nxt};
      end
      S_RD_R: begin
        rd_d   = 1'b1;
        addr_d = ADDR_R0 + {2'b00, idx_nxt};
      end
      S_CLR_SET: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_byte(func_q, 1'b1, 1'b0);
      end
      S_CLR_REL: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_byte(func_q, 1'b0, 1'b0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_pi_master.sv
// Testbench for alu_pi_master: behavioural ALU register responder, bus
// logger, a table of directed commands and hand-written reset/back-to-back
// sequences.
module tb_alu_pi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_func;
  logic [31:0] cmd_op_a, cmd_op_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_q, rsp_r;
  logic        rsp_err;
  logic        pi_blk_sel, pi_wr_en, pi_rd_en;
  logic [3:0]  pi_addr;
  logic [7:0]  pi_wr_data, pi_rd_data;

  alu_pi_master #(.POLL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .pi_blk_sel(pi_blk_sel), .pi_addr(pi_addr), .pi_wr_en(pi_wr_en),
    .pi_rd_en(pi_rd_en), .pi_wr_data(pi_wr_data), .pi_rd_data(pi_rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int proto_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural ALU register block.
  logic        busy = 1'b0;
  int          pcnt = 0;
  int          busy_polls = 1;
  logic [31:0] r_q = 32'd0, r_r = 32'd0;

  always_comb begin
    pi_rd_data = 8'd0;
    if (pi_addr == 4'd0)                        pi_rd_data = {7'd0, busy};
    else if (pi_addr >= 4'd1 && pi_addr <= 4'd4) pi_rd_data = r_q[8*(pi_addr-4'd1) +: 8];
    else if (pi_addr >= 4'd5 && pi_addr <= 4'd8) pi_rd_data = r_r[8*(pi_addr-4'd5) +: 8];
  end

  always @(posedge clk) begin
    if (pi_wr_en && pi_addr == 4'd0 && pi_wr_data[0]) begin
      busy <= 1'b1;
      pcnt <= 0;
    end else if (pi_rd_en && pi_addr == 4'd0 && busy) begin
      pcnt <= pcnt + 1;
      if (pcnt + 1 >= busy_polls) busy <= 1'b0;
    end
  end

  // Bus logger and strobe consistency monitor.
  typedef struct {
    int         c;
    logic       wr;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } bus_t;
  bus_t blog[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (pi_blk_sel !== (pi_wr_en | pi_rd_en) || (pi_wr_en & pi_rd_en)) proto_err++;
      if (pi_blk_sel === 1'b1)
        blog.push_back('{c: cyc, wr: pi_wr_en, rd: pi_rd_en, addr: pi_addr,
                         data: pi_wr_en ? pi_wr_data : 8'd0});
    end
  end

  typedef struct {
    logic [3:0]  func;
    logic [31:0] a, b;
    int          bpolls;
    logic [31:0] rq, rr;
    int          hold;
    logic [31:0] q, r;
    logic        err;
    int          npolls;
    int          lat;
    logic [7:0]  go, cset, crel;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int   c0, t;
    bit   hold_ok;
    bus_t ex[$];
    string p;
    p = $sformatf("v%0d", id);
    r_q = v.rq; r_r = v.rr; busy_polls = v.bpolls;
    blog.delete();
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk({p, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_func = v.func; cmd_op_a = v.a; cmd_op_b = v.b;
    c0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_func = ~v.func; cmd_op_a = ~v.a; cmd_op_b = ~v.b;
    chk({p, "_ready_busy"}, cmd_ready, 0);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    chk({p, "_rsp_valid"}, rsp_valid, 1);
    chk({p, "_latency"}, cyc - c0, v.lat);
    chk({p, "_rsp_q"}, rsp_q, v.q);
    chk({p, "_rsp_r"}, rsp_r, v.r);
    chk({p, "_rsp_err"}, rsp_err, v.err);
    hold_ok = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_q !== v.q || rsp_r !== v.r ||
          rsp_err !== v.err || cmd_ready !== 1'b0) hold_ok = 1'b0;
    end
    chk({p, "_hold_stable"}, hold_ok, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({p, "_rsp_done"}, rsp_valid, 0);
    chk({p, "_ready_again"}, cmd_ready, 1);
    // Expected bus transcript.
    for (int k = 0; k < 4; k++) ex.push_back('{0, 1'b1, 1'b0, 4'(1 + k), v.a[8*k +: 8]});
    for (int k = 0; k < 4; k++) ex.push_back('{0, 1'b1, 1'b0, 4'(5 + k), v.b[8*k +: 8]});
    ex.push_back('{0, 1'b1, 1'b0, 4'd0, v.go});
    for (int k = 0; k < v.npolls; k++) ex.push_back('{0, 1'b0, 1'b1, 4'd0, 8'd0});
    if (v.err) begin
      ex.push_back('{0, 1'b1, 1'b0, 4'd0, v.cset});
      ex.push_back('{0, 1'b1, 1'b0, 4'd0, v.crel});
    end else begin
      for (int k = 0; k < 8; k++) ex.push_back('{0, 1'b0, 1'b1, 4'(1 + k), 8'd0});
    end
    chk({p, "_bus_len"}, blog.size(), ex.size());
    for (int i = 0; i < ex.size() && i < blog.size(); i++) begin
      chk($sformatf("%s_bus%0d", p, i),
          {blog[i].c, blog[i].wr, blog[i].rd, blog[i].addr, blog[i].data},
          {c0 + 1 + i, ex[i].wr, ex[i].rd, ex[i].addr, ex[i].data});
    end
  endtask

  vec_t vecs[4];

  initial begin
    int  t, np, c0;
    bit  seen;

    vecs[0] = '{func: 4'h2, a: 32'h12345678, b: 32'h9ABCDEF0, bpolls: 3,
                rq: 32'hDEADBEEF, rr: 32'h00000007, hold: 0,
                q: 32'hDEADBEEF, r: 32'h00000007, err: 1'b0, npolls: 4, lat: 22,
                go: 8'h23, cset: 8'h00, crel: 8'h00};
    vecs[1] = '{func: 4'h5, a: 32'hFFFFFFFF, b: 32'h00000001, bpolls: 1,
                rq: 32'h01020304, rr: 32'hA5A5A5A5, hold: 10,
                q: 32'h01020304, r: 32'hA5A5A5A5, err: 1'b0, npolls: 2, lat: 20,
                go: 8'h53, cset: 8'h00, crel: 8'h00};
    vecs[2] = '{func: 4'hF, a: 32'h80000000, b: 32'h0000FFFF, bpolls: 7,
                rq: 32'h11223344, rr: 32'h55667788, hold: 0,
                q: 32'h11223344, r: 32'h55667788, err: 1'b0, npolls: 8, lat: 26,
                go: 8'hF3, cset: 8'h00, crel: 8'h00};
    vecs[3] = '{func: 4'h2, a: 32'hCAFEF00D, b: 32'h00000003, bpolls: 1000,
                rq: 32'h99999999, rr: 32'h77777777, hold: 0,
                q: 32'h00000000, r: 32'h00000000, err: 1'b1, npolls: 8, lat: 20,
                go: 8'h23, cset: 8'h2A, crel: 8'h22};

    // Reset held with a command pending: everything quiet.
    rst = 1'b1; cmd_valid = 1'b1; cmd_func = 4'h2;
    cmd_op_a = 32'h1; cmd_op_b = 32'h2; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outputs%0d", i),
          {pi_blk_sel, pi_wr_en, pi_rd_en, pi_addr, pi_wr_data, rsp_valid,
           rsp_err, cmd_ready, rsp_q[15:0], rsp_r[15:0]}, 64'd0);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("reset_ready_after", cmd_ready, 1);
    chk("reset_no_strobe", pi_blk_sel, 0);

    // Directed command table (includes backpressure and timeout).
    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Reset asserted during the second status poll.
    busy_polls = 1000;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    cmd_valid = 1'b1; cmd_func = 4'h3; cmd_op_a = 32'h5; cmd_op_b = 32'h6;
    @(negedge clk);
    cmd_valid = 1'b0;
    np = 0; t = 0;
    while (np < 2 && t < 100) begin
      @(negedge clk); t++;
      if (pi_rd_en === 1'b1 && pi_addr == 4'd0) np++;
    end
    chk("rstmid_reached_poll2", np, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_strobes", {pi_blk_sel, pi_wr_en, pi_rd_en}, 0);
    chk("rstmid_ready", cmd_ready, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || pi_blk_sel !== 1'b0) seen = 1'b1;
    end
    chk("rstmid_quiet", seen, 0);
    run_vec(vecs[0], 4);

    // Back-to-back commands with cmd_valid held and rsp_ready tied high.
    busy_polls = 2; r_q = 32'h0BADF00D; r_r = 32'h00000011;
    rsp_ready = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    cmd_valid = 1'b1; cmd_func = 4'h1; cmd_op_a = 32'hAA; cmd_op_b = 32'hBB;
    @(negedge clk);
    cmd_func = 4'h4; cmd_op_a = 32'hCC; cmd_op_b = 32'hDD;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    chk("b2b_first_valid", rsp_valid, 1);
    chk("b2b_first_q", rsp_q, 32'h0BADF00D);
    chk("b2b_first_r", rsp_r, 32'h00000011);
    r_q = 32'h12121212; r_r = 32'h34343434;
    @(negedge clk);
    chk("b2b_ready_next", cmd_ready, 1);
    chk("b2b_first_done", rsp_valid, 0);
    c0 = cyc;
    blog.delete();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_accepted", cmd_ready, 0);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    chk("b2b_second_latency", cyc - c0, 21);
    chk("b2b_second_q", rsp_q, 32'h12121212);
    chk("b2b_second_r", rsp_r, 32'h34343434);
    chk("b2b_second_err", rsp_err, 0);
    chk("b2b_second_opa", blog.size() > 0 ? blog[0].data : 8'hXX, 8'hCC);
    chk("b2b_second_go", blog.size() > 8 ? blog[8].data : 8'hXX, 8'h43);
    @(negedge clk);
    rsp_ready = 1'b0;

    chk("strobe_protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
